// File: rtl/stack_ctl.sv
// Parametrised LIFO with registered top, depth count, full/empty status,
// sticky overflow/underflow flags, replace-top on push+pop, and a peek port.
module stack_ctl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pushd,
    input  logic                  push_en,
    input  logic                  pop_en,
    input  logic                  err_clr,
    input  logic [ADDR_WIDTH-1:0] peek_idx,
    output logic [DATA_WIDTH-1:0] top,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DATA_WIDTH-1:0] peek_data,
    output logic                  peek_valid
);

    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    // Depth 0 lives in top_q; mem holds depths 1..DEPTH-1, oldest at mem[0].
    logic [DATA_WIDTH-1:0] mem [DEPTH-1];

    logic [DATA_WIDTH-1:0] top_d, top_q;
    logic [ADDR_WIDTH:0]   count_d, count_q;
    logic                  ovf_d, ovf_q;
    logic                  unf_d, unf_q;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [ADDR_WIDTH:0]   cnt_m1, cnt_m2, peek_pos;
    logic                  is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign cnt_m1   = count_q - ONE;
    assign cnt_m2   = count_q - (ADDR_WIDTH+1)'(2);
    assign peek_pos = cnt_m1 - {1'b0, peek_idx};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        top_d     = top_q;
        count_d   = count_q;
        ovf_d     = ovf_q & ~err_clr;
        unf_d     = unf_q & ~err_clr;
        mem_we    = 1'b0;
        mem_waddr = cnt_m1[ADDR_WIDTH-1:0];
        mem_wdata = top_q;

        case ({push_en, pop_en})
            2'b10: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = !is_empty;
                    top_d   = pushd;
                    count_d = count_q + ONE;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = cnt_m1;
                    top_d   = (count_q == ONE) ? '0 : mem[cnt_m2[ADDR_WIDTH-1:0]];
                end
            end
            2'b11: begin
                // Replace top; on an empty stack only the push half can execute.
                top_d = pushd;
                if (is_empty) begin
                    count_d = ONE;
                    unf_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which
    // entries are live, so clearing the array would only cost hardware.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        peek_valid = ({1'b0, peek_idx} < count_q);
        peek_data  = '0;
        if (peek_valid) begin
            peek_data = (peek_idx == '0) ? top_q : mem[peek_pos[ADDR_WIDTH-1:0]];
        end
    end

    assign top       = top_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_ctl.sv
// Bench for stack_ctl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stack_ctl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pushd;
    logic          push_en, pop_en, err_clr;
    logic [AW-1:0] peek_idx;
    logic [DW-1:0] top;
    logic [AW:0]   count;
    logic          empty, full, overflow, underflow;
    logic [DW-1:0] peek_data;
    logic          peek_valid;

    stack_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pushd(pushd), .push_en(push_en),
        .pop_en(pop_en), .err_clr(err_clr), .peek_idx(peek_idx),
        .top(top), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow),
        .peek_data(peek_data), .peek_valid(peek_valid)
    );

    always #5 clk = ~clk;

    // Reference model: queue with the newest entry at the back.
    logic [DW-1:0] stk[$];
    bit            m_ovf, m_unf;
    bit            cmp_en = 1'b0;
    int            n_vec  = 0;
    int            n_err  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_top();
        return (stk.size() == 0) ? '0 : stk[stk.size()-1];
    endfunction

    function automatic logic [DW-1:0] m_peek(input int idx);
        return (idx < stk.size()) ? stk[stk.size()-1-idx] : '0;
    endfunction

    task automatic model_edge(input bit pu, input bit po, input bit cl, input logic [DW-1:0] d);
        if (cl) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (pu && po) begin
            if (stk.size() == 0) begin
                stk.push_back(d);
                m_unf = 1'b1;
            end else begin
                stk[stk.size()-1] = d;
            end
        end else if (pu) begin
            if (stk.size() == DEPTH) m_ovf = 1'b1;
            else stk.push_back(d);
        end else if (po) begin
            if (stk.size() == 0) m_unf = 1'b1;
            else void'(stk.pop_back());
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("top",        top,        m_top());
            check("count",      count,      stk.size());
            check("empty",      empty,      stk.size() == 0);
            check("full",       full,       stk.size() == DEPTH);
            check("overflow",   overflow,   m_ovf);
            check("underflow",  underflow,  m_unf);
            check("peek_data",  peek_data,  m_peek(int'(peek_idx)));
            check("peek_valid", peek_valid, int'(peek_idx) < stk.size());
        end
    end

    // Drive one request, let the edge happen, advance the model, settle 1 time unit.
    task automatic step(input bit pu, input bit po, input bit cl,
                        input logic [DW-1:0] d, input logic [AW-1:0] pi);
        push_en  = pu;
        pop_en   = po;
        err_clr  = cl;
        pushd    = d;
        peek_idx = pi;
        @(posedge clk);
        model_edge(pu, po, cl, d);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_top"},   top,       8'h00);
        check({tag, "_count"}, count,     3'd0);
        check({tag, "_empty"}, empty,     1'b1);
        check({tag, "_full"},  full,      1'b0);
        check({tag, "_ovf"},   overflow,  1'b0);
        check({tag, "_unf"},   underflow, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; push_en = 1'b0; pop_en = 1'b0; err_clr = 1'b0;
        pushd = '0; peek_idx = '0;
        model_reset();
        #3;
        check_reset_state("rst");
        #10 rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // Fill to capacity.
        step(1, 0, 0, 8'h11, 0);
        step(1, 0, 0, 8'h22, 0);
        step(1, 0, 0, 8'h33, 0);
        step(1, 0, 0, 8'h44, 3);
        check("fill_top", top, 8'h44);
        check("fill_count", count, 3'd4);
        check("fill_full", full, 1'b1);
        check("fill_peek3", peek_data, 8'h11);
        check("fill_peek3_v", peek_valid, 1'b1);

        // Overflow, then drain.
        step(1, 0, 0, 8'h55, 0);
        check("ovf_top", top, 8'h44);
        check("ovf_flag", overflow, 1'b1);
        step(0, 1, 0, 8'h00, 0); check("drain1", top, 8'h33);
        step(0, 1, 0, 8'h00, 0); check("drain2", top, 8'h22);
        step(0, 1, 0, 8'h00, 0); check("drain3", top, 8'h11);
        step(0, 1, 0, 8'h00, 0); check("drain4", top, 8'h00);
        check("drain_count", count, 3'd0);
        check("drain_empty", empty, 1'b1);

        // Underflow and flag clear priority.
        step(0, 1, 0, 8'h00, 0);
        check("unf_set", underflow, 1'b1);
        step(0, 1, 1, 8'h00, 0);
        check("unf_clr_vs_new", underflow, 1'b1);
        step(0, 0, 1, 8'h00, 0);
        check("unf_cleared", underflow, 1'b0);
        check("ovf_cleared", overflow, 1'b0);

        // Replace top, including while full.
        step(1, 0, 0, 8'hA0, 0);
        step(1, 0, 0, 8'hA1, 0);
        step(1, 1, 0, 8'hB0, 1);
        check("rep_top", top, 8'hB0);
        check("rep_count", count, 3'd2);
        check("rep_peek1", peek_data, 8'hA0);
        step(1, 0, 0, 8'hC0, 0);
        step(1, 0, 0, 8'hC1, 0);
        step(1, 1, 0, 8'hD0, 2);
        check("rep_full_top", top, 8'hD0);
        check("rep_full_count", count, 3'd4);
        check("rep_full_ovf", overflow, 1'b0);
        check("rep_full_peek2", peek_data, 8'hB0);

        // Push+pop on empty.
        repeat (4) step(0, 1, 0, 8'h00, 0);
        step(1, 1, 0, 8'h7E, 1);
        check("pp_empty_top", top, 8'h7E);
        check("pp_empty_count", count, 3'd1);
        check("pp_empty_unf", underflow, 1'b1);
        check("pp_empty_peek", peek_data, 8'h00);
        check("pp_empty_peek_v", peek_valid, 1'b0);

        // Asynchronous reset between edges.
        step(1, 0, 1, 8'h01, 0);
        step(1, 0, 0, 8'h02, 0);
        step(0, 0, 0, 8'h00, 0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("async");
        #2 rst_n = 1'b1;
        step(0, 1, 0, 8'h00, 0);
        check("post_rst_unf", underflow, 1'b1);
        check("post_rst_count", count, 3'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit pu, po, cl;
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            cl = ($urandom_range(0, 99) < 8);
            step(pu, po, cl, 8'($urandom), AW'($urandom));
        end

        step(0, 0, 0, 8'h00, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stack_ctl.md
Name: stack_ctl

Overview:
- Parametrised LIFO stack and successor to the basic push/pop stack used for loop nesting in the processor.
- Adds an explicit depth count, full and empty flags, and sticky overflow/underflow error flags.
- Adds simultaneous push+pop (replace top) and a combinational peek port for reading any live entry.
- Used by the control unit for loop-return addresses and by debug logic to inspect nesting.

Parameters:
- DATA_WIDTH, 8, width of each stored value.
- ADDR_WIDTH, 5, capacity DEPTH = 2^ADDR_WIDTH entries, including the top entry.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pushd  input  DATA_WIDTH  data for a push.
- push_en  input  1  push on this clock edge.
- pop_en  input  1  pop on this clock edge.
- err_clr  input  1  clear the sticky error flags.
- peek_idx  input  ADDR_WIDTH  depth to inspect; 0 = top.
- top  output  DATA_WIDTH  registered top-of-stack value; 0 when empty.
- count  output  ADDR_WIDTH+1  number of live entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a push was dropped.
- underflow  output  1  sticky flag: a pop was dropped.
- peek_data  output  DATA_WIDTH  entry at depth peek_idx; 0 if not live.
- peek_valid  output  1  peek_idx < count.

Behaviour:
- Storage:
  - top register holds depth 0.
  - Array mem[0..DEPTH-2] holds deeper entries; mem[count-2] is depth 1 and mem[0] is the oldest.
- Reset (rst_n low, asynchronous, takes effect immediately):
  - top=0, count=0, overflow=0, underflow=0, so empty=1 and full=0.
  - mem contents are not reset.
  - Reset mid-operation discards all entries.
  - First edge after release behaves as from empty.
- Push only, not full:
  - If count>0, mem[count-1] <= top.
  - top <= pushd, count <= count+1.
- Push only, full: state unchanged, overflow <= 1.
- Pop only, count >= 2: top <= mem[count-2], count <= count-1.
- Pop only, count == 1: top <= 0, count <= 0.
- Pop only, empty: state unchanged, underflow <= 1.
- Push and pop together, count > 0: replace top.
  - top <= pushd, count unchanged, mem unchanged.
  - No error flag, including when full.
- Push and pop together, empty: push executes (top <= pushd, count <= 1), pop is dropped, underflow <= 1.
- Error flags:
  - err_clr clears both flags on the edge.
  - A new error in the same cycle as err_clr wins: that flag reads 1.
- Latency:
  - top, count, flags update one edge after the request.
  - A push followed by a pop on the next cycle returns the pushed value; back-to-back operations every cycle are supported.
- Status timing: empty and full derive combinationally from registered count.
- peek_data is combinational from peek_idx and the current registered state:
  - idx 0 gives top.
  - 0 < idx < count gives mem[count-1-idx].
  - Otherwise peek_data = 0 and peek_valid = 0.
- Width rules:
  - count is ADDR_WIDTH+1 bits, so DEPTH is representable.
  - No pointer wrap ever occurs; overflow is blocked by the full check.
- Edge behaviour:
  - Inputs are sampled on the rising edge only.
  - An idle cycle (push_en=pop_en=0) holds all state.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4):
- Reset, then push 0x11,0x22,0x33,0x44 on consecutive edges -> top=0x44, count=4, full=1. peek_idx=3 -> peek_data=0x11, peek_valid=1.
- From full, push 0x55 -> top=0x44, count=4, overflow=1. Then pop four times -> top sequence 0x33,0x22,0x11,0x00, count ends at 0, empty=1.
- Pop on empty -> underflow=1, count=0. Assert err_clr and pop together -> underflow stays 1. err_clr alone -> underflow=0.
- Push 0xA0,0xA1, then push 0xB0 with pop in the same cycle -> top=0xB0, count=2, peek_idx=1 -> 0xA0. Repeat while full -> no overflow.
- Empty, push 0x7E with pop in the same cycle -> top=0x7E, count=1, underflow=1. peek_idx=1 -> peek_data=0, peek_valid=0.
- Push 0x01,0x02, then assert rst_n low between edges -> top=0, count=0, empty=1 immediately. After release, pop -> underflow=1.
